mc_resid_injector: RTL and testbench

Residual-multicast re-injection buffer for the bufferless multicast router. It accepts flits whose productive ports were only partly served by the switch allocator, along with the still-unserved port vector. It holds them in a small circular queue and re-offers the head flit to the allocator every cycle. With each grant it narrows the head's port vector and retires the entry once every destination port has been served.

---
 rtl/mc_resid_injector.sv | 130 +++++++++++++
 tb/tb_mc_resid_injector.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_resid_injector.sv
// Residual-multicast re-injection queue: holds partly served flits and re-offers the head until all ports are served.
// Optional build macro MC_AGE_PRIORITY_EN adds per-entry age counters and the inj_urgent flag; NUM_PORT (default 5) sets the port-vector width.
`ifndef NUM_PORT
`define NUM_PORT 5
`endif

module mc_resid_injector #(
    parameter int DEPTH      = 4,
    parameter int FLIT_WIDTH = 64,
    parameter int AGE_MAX    = 8,
    localparam int NPV       = `NUM_PORT - 1,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  resid_valid,
    output logic                  resid_ready,
    input  logic [NPV-1:0]        resid_ppv,
    input  logic [FLIT_WIDTH-1:0] resid_flit,
    output logic                  inj_valid,
    output logic [NPV-1:0]        inj_ppv,
    output logic [FLIT_WIDTH-1:0] inj_flit,
    output logic                  inj_urgent,
    input  logic                  inj_grant,
    input  logic [NPV-1:0]        inj_alloc,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  empty
);
    localparam int PW = $clog2(DEPTH);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
        $error("mc_resid_injector: DEPTH must be a power of two in 2..16");
    end
    if (AGE_MAX < 1 || AGE_MAX > 15) begin : gBadAge
        $error("mc_resid_injector: AGE_MAX must be in 1..15");
    end

    typedef enum logic {EMPTY, OFFER} headState_t;
    headState_t state;

    logic [PW-1:0]         wrPtr, rdPtr;
    logic [NPV-1:0]        ppvMem  [DEPTH];
    logic [FLIT_WIDTH-1:0] flitMem [DEPTH];
    logic [NPV-1:0]        headPpv, newPpv;
    logic                  pushFire, headUpd, popFire;
    logic [CW-1:0]         countNext;

    assign headPpv  = ppvMem[rdPtr];
    // Alloc bits outside the head vector fall away naturally in the mask.
    assign newPpv   = headPpv & ~inj_alloc;
    assign pushFire = resid_valid && resid_ready && (|resid_ppv);
    assign headUpd  = inj_valid && inj_grant;
    assign popFire  = headUpd && (newPpv == '0);

    always_comb begin
        countNext = count;
        if (pushFire && !popFire) begin
            countNext = count + CW'(1);
        end else if (!pushFire && popFire) begin
            countNext = count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            resid_ready <= 1'b1;
            state       <= EMPTY;
        end else begin
            if (pushFire) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (popFire) begin
                rdPtr <= rdPtr + PW'(1);
            end
            count       <= countNext;
            full        <= (countNext == CW'(DEPTH));
            empty       <= (countNext == '0);
            resid_ready <= (countNext != CW'(DEPTH));
            case (state)
                EMPTY: if (pushFire) state <= OFFER;
                OFFER: if (popFire && !pushFire && count == CW'(1)) state <= EMPTY;
                default: state <= EMPTY;
            endcase
        end
    end

    // Push and head update never share an address: push needs !full, update needs !empty.
    always_ff @(posedge clk) begin
        if (pushFire) begin
            ppvMem[wrPtr]  <= resid_ppv;
            flitMem[wrPtr] <= resid_flit;
        end
        if (headUpd && !popFire) begin
            ppvMem[rdPtr] <= newPpv;
        end
    end

    assign inj_valid = (state == OFFER);
    assign inj_ppv   = inj_valid ? headPpv : '0;
    assign inj_flit  = inj_valid ? flitMem[rdPtr] : '0;

`ifdef MC_AGE_PRIORITY_EN
    logic [3:0] ageVec [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : gAge
        logic [3:0] ageReg;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                ageReg <= '0;
            end else if (pushFire && wrPtr == PW'(gi)) begin
                ageReg <= '0;
            end else if (headUpd && !popFire && rdPtr == PW'(gi) && ageReg != 4'hF) begin
                ageReg <= ageReg + 4'd1;
            end
        end
        assign ageVec[gi] = ageReg;
    end

    assign inj_urgent = inj_valid && (ageVec[rdPtr] >= 4'(AGE_MAX));
`else
    assign inj_urgent = 1'b0;
`endif

endmodule

// File: tb/tb_mc_resid_injector.sv
// Randomized and directed bench for mc_resid_injector against a queue-based reference model.
`ifndef NUM_PORT
`define NUM_PORT 5
`endif

module tb_mc_resid_injector;
    localparam int DEPTH   = 4;
    localparam int FW      = 64;
    localparam int AGE_MAX = 3;
    localparam int NPV     = `NUM_PORT - 1;
    localparam int CW      = $clog2(DEPTH + 1);

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           resid_valid = 1'b0;
    logic           resid_ready;
    logic [NPV-1:0] resid_ppv = '0;
    logic [FW-1:0]  resid_flit = '0;
    logic           inj_valid;
    logic [NPV-1:0] inj_ppv;
    logic [FW-1:0]  inj_flit;
    logic           inj_urgent;
    logic           inj_grant = 1'b0;
    logic [NPV-1:0] inj_alloc = '0;
    logic [CW-1:0]  count;
    logic           full;
    logic           empty;

    int checks = 0;
    int errors = 0;

    // Reference model: three parallel queues, index 0 is the head.
    logic [NPV-1:0] qPpv[$];
    logic [FW-1:0]  qFlit[$];
    int             qAge[$];

    always #5 clk = ~clk;

    mc_resid_injector #(.DEPTH(DEPTH), .FLIT_WIDTH(FW), .AGE_MAX(AGE_MAX)) dut (
        .clk(clk), .reset(reset),
        .resid_valid(resid_valid), .resid_ready(resid_ready),
        .resid_ppv(resid_ppv), .resid_flit(resid_flit),
        .inj_valid(inj_valid), .inj_ppv(inj_ppv), .inj_flit(inj_flit),
        .inj_urgent(inj_urgent), .inj_grant(inj_grant), .inj_alloc(inj_alloc),
        .count(count), .full(full), .empty(empty)
    );

    function automatic logic expUrgent();
`ifdef MC_AGE_PRIORITY_EN
        return (qPpv.size() > 0) && (qAge[0] >= AGE_MAX);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [NPV-1:0] expPpv();
        return (qPpv.size() > 0) ? qPpv[0] : '0;
    endfunction

    function automatic logic [FW-1:0] expFlit();
        return (qFlit.size() > 0) ? qFlit[0] : '0;
    endfunction

    // One clock cycle: drive inputs, advance the model, return #1 after the edge.
    task automatic cycle(input logic rv, input logic [NPV-1:0] rp, input logic [FW-1:0] rf,
                         input logic g, input logic [NPV-1:0] a);
        logic doPush, doPop;
        logic [NPV-1:0] nv;
        resid_valid = rv; resid_ppv = rp; resid_flit = rf; inj_grant = g; inj_alloc = a;
        doPush = rv && (qPpv.size() < DEPTH) && (rp != '0);
        doPop  = 1'b0;
        if (qPpv.size() > 0 && g) begin
            nv = qPpv[0] & ~a;
            if (nv == '0) begin
                doPop = 1'b1;
            end else begin
                qPpv[0] = nv;
                if (qAge[0] < 15) qAge[0] = qAge[0] + 1;
            end
        end
        if (doPop) begin
            qPpv.delete(0); qFlit.delete(0); qAge.delete(0);
        end
        if (doPush) begin
            qPpv.push_back(rp); qFlit.push_back(rf); qAge.push_back(0);
        end
        @(posedge clk);
        #1;
        $display("txn t=%0t rv=%0b ppv=%h grant=%0b alloc=%h push=%0b pop=%0b count=%0d",
                 $time, rv, rp, g, a, doPush, doPop, count);
    endtask

    task automatic test_reset();
        #12;
        checks++; if (resid_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", resid_ready); end
        checks++; if (inj_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", inj_valid); end
        checks++; if (inj_ppv !== '0) begin errors++; $display("FAIL reset_ppv got %h exp 0", inj_ppv); end
        checks++; if (inj_flit !== '0) begin errors++; $display("FAIL reset_flit got %h exp 0", inj_flit); end
        checks++; if (inj_urgent !== 1'b0) begin errors++; $display("FAIL reset_urgent got %b exp 0", inj_urgent); end
        checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (full !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL reset_flags got full=%b empty=%b exp 0/1", full, empty); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        cycle(1'b1, NPV'(4'b1011), FW'(64'hA5), 1'b0, '0);
        checks++; if (inj_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", inj_valid); end
        checks++; if (inj_ppv !== NPV'(4'b1011)) begin errors++; $display("FAIL basic_ppv got %b exp 1011", inj_ppv); end
        checks++; if (count !== CW'(1)) begin errors++; $display("FAIL basic_count got %0d exp 1", count); end
        checks++; if (inj_flit !== FW'(64'hA5)) begin errors++; $display("FAIL basic_flit got %h exp a5", inj_flit); end
        cycle(1'b0, '0, '0, 1'b1, NPV'(4'b0001));
        checks++; if (inj_ppv !== NPV'(4'b1010)) begin errors++; $display("FAIL grant1_ppv got %b exp 1010", inj_ppv); end
        cycle(1'b0, '0, '0, 1'b1, NPV'(4'b1000));
        checks++; if (inj_ppv !== NPV'(4'b0010)) begin errors++; $display("FAIL grant2_ppv got %b exp 0010", inj_ppv); end
        cycle(1'b0, '0, '0, 1'b1, NPV'(4'b0010));
        checks++; if (empty !== 1'b1 || inj_valid !== 1'b0 || count !== '0) begin
            errors++; $display("FAIL grant3_pop got empty=%b valid=%b count=%0d exp 1/0/0", empty, inj_valid, count);
        end
    endtask

    task automatic test_full_wrap();
        logic [NPV-1:0] p;
        logic [FW-1:0]  f;
        for (int i = 0; i < DEPTH; i++) begin
            p = NPV'($urandom_range(1, (1 << NPV) - 1));
            f = {$urandom, $urandom};
            cycle(1'b1, p, f, 1'b0, '0);
        end
        checks++; if (full !== 1'b1 || resid_ready !== 1'b0 || count !== CW'(DEPTH)) begin
            errors++; $display("FAIL full_flags got full=%b ready=%b count=%0d exp 1/0/%0d", full, resid_ready, count, DEPTH);
        end
        for (int r = 0; r < 6; r++) begin
            p = NPV'($urandom_range(1, (1 << NPV) - 1));
            f = {$urandom, $urandom};
            cycle(1'b1, p, f, 1'b0, '0);
            checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL full_reject got %0d exp %0d", count, DEPTH); end
            cycle(1'b1, p, f, 1'b1, '1);
            checks++; if (count !== CW'(DEPTH - 1) || resid_ready !== 1'b1) begin
                errors++; $display("FAIL full_pop got count=%0d ready=%b exp %0d/1", count, resid_ready, DEPTH - 1);
            end
            checks++; if (inj_flit !== expFlit()) begin errors++; $display("FAIL wrap_head got %h exp %h", inj_flit, expFlit()); end
            cycle(1'b1, p, f, 1'b0, '0);
            checks++; if (count !== CW'(DEPTH) || full !== 1'b1) begin
                errors++; $display("FAIL refill got count=%0d full=%b exp %0d/1", count, full, DEPTH);
            end
        end
        while (qPpv.size() > 0) begin
            cycle(1'b0, '0, '0, 1'b1, '1);
            checks++; if (count !== CW'(qPpv.size()) || inj_flit !== expFlit()) begin
                errors++; $display("FAIL drain got count=%0d flit=%h exp %0d/%h", count, inj_flit, qPpv.size(), expFlit());
            end
        end
    endtask

    task automatic test_zero_ppv();
        cycle(1'b1, '0, {$urandom, $urandom}, 1'b0, '0);
        checks++; if (count !== '0 || empty !== 1'b1) begin errors++; $display("FAIL zero_ppv got count=%0d empty=%b exp 0/1", count, empty); end
        cycle(1'b1, NPV'(4'b0110), FW'(64'h1111), 1'b0, '0);
        cycle(1'b1, NPV'(4'b0001), FW'(64'h2222), 1'b0, '0);
        cycle(1'b1, NPV'(4'b1100), FW'(64'h3333), 1'b1, '1);
        checks++; if (count !== CW'(2)) begin errors++; $display("FAIL pushpop_count got %0d exp 2", count); end
        checks++; if (inj_flit !== FW'(64'h2222)) begin errors++; $display("FAIL pushpop_head got %h exp 2222", inj_flit); end
        cycle(1'b0, '0, '0, 1'b1, '1);
        checks++; if (inj_flit !== FW'(64'h3333) || inj_ppv !== NPV'(4'b1100)) begin
            errors++; $display("FAIL pushpop_order got %h/%b exp 3333/1100", inj_flit, inj_ppv);
        end
        cycle(1'b0, '0, '0, 1'b1, '1);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pushpop_drain got empty=%b exp 1", empty); end
    endtask

    task automatic test_age();
        cycle(1'b1, NPV'(4'b0101), {$urandom, $urandom}, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, '0, 1'b1, '0);
            checks++; if (inj_urgent !== expUrgent() || inj_ppv !== NPV'(4'b0101)) begin
                errors++; $display("FAIL age_step%0d got urgent=%b ppv=%b exp %b/0101", i, inj_urgent, inj_ppv, expUrgent());
            end
        end
        cycle(1'b0, '0, '0, 1'b1, '1);
        checks++; if (inj_urgent !== 1'b0 || empty !== 1'b1) begin
            errors++; $display("FAIL age_clear got urgent=%b empty=%b exp 0/1", inj_urgent, empty);
        end
    endtask

    task automatic test_random();
        logic rv, g;
        logic [NPV-1:0] rp, a;
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom % 4) != 0;
            rp = (($urandom % 6) == 0) ? '0 : NPV'($urandom);
            g  = ($urandom % 2) != 0;
            a  = (($urandom % 3) == 0) ? '1 : NPV'($urandom);
            cycle(rv, rp, {$urandom, $urandom}, g, a);
            checks++;
            if (count !== CW'(qPpv.size()) || inj_valid !== (qPpv.size() > 0) ||
                inj_ppv !== expPpv() || inj_flit !== expFlit() ||
                full !== (qPpv.size() == DEPTH) || empty !== (qPpv.size() == 0) ||
                resid_ready !== (qPpv.size() < DEPTH) || inj_urgent !== expUrgent()) begin
                errors++;
                $display("FAIL random%0d got cnt=%0d v=%b ppv=%h flit=%h f=%b e=%b rdy=%b urg=%b exp cnt=%0d ppv=%h flit=%h urg=%b",
                         i, count, inj_valid, inj_ppv, inj_flit, full, empty, resid_ready, inj_urgent,
                         qPpv.size(), expPpv(), expFlit(), expUrgent());
            end
        end
    endtask

    task automatic test_reset_mid();
        while (qPpv.size() > 0) cycle(1'b0, '0, '0, 1'b1, '1);
        for (int i = 0; i < 3; i++) cycle(1'b1, NPV'($urandom_range(1, (1 << NPV) - 1)), {$urandom, $urandom}, 1'b0, '0);
        checks++; if (count !== CW'(3)) begin errors++; $display("FAIL pre_reset_count got %0d exp 3", count); end
        #3 reset = 1'b1;
        #1;
        checks++; if (count !== '0 || inj_valid !== 1'b0 || empty !== 1'b1 || resid_ready !== 1'b1) begin
            errors++; $display("FAIL async_reset got count=%0d valid=%b empty=%b ready=%b exp 0/0/1/1", count, inj_valid, empty, resid_ready);
        end
        qPpv.delete(); qFlit.delete(); qAge.delete();
        #2 reset = 1'b0;
        cycle(1'b1, NPV'(4'b0011), FW'(64'h77), 1'b0, '0);
        checks++; if (count !== CW'(1) || inj_flit !== FW'(64'h77)) begin
            errors++; $display("FAIL post_reset_push got count=%0d flit=%h exp 1/77", count, inj_flit);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_wrap();
        test_zero_ppv();
        test_age();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
